apple_spawner: RTL and testbench
================================

// Module: apple_spawner
// PURPOSE
//  Food source for the snake game. Holds the apple's grid cell and watches the snake head position.
//  When the head lands on the apple, it drives the add_cube grow request to the snake movement block.
//  It then places a new apple at a pseudo-random legal cell and answers pixel queries from the VGA scan.
//  Sits between the snake movement block (head_x/head_y in, add_cube out) and the pixel colour mux.
// PARAMETERS
//  ADD_HOLD   4        cycles add_cube stays high per eat event (1..15)
//  LFSR_SEED  16'hACE1 LFSR value loaded at reset/RESTART; must be non-zero
//  START_X    24       apple grid x after reset/RESTART (1..38)
//  START_Y    10       apple grid y after reset/RESTART (1..28)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous active-low reset
//  game_status  in   2   2'b00 RESTART, 2'b10 PLAY, other codes = not playing
//  head_x       in   6   snake head grid x
//  head_y       in   6   snake head grid y
//  x_pos        in   10  VGA scan pixel x
//  y_pos        in   10  VGA scan pixel y
//  add_cube     out  1   grow request; level, held ADD_HOLD cycles per eat
//  apple_x      out  6   current apple grid x
//  apple_y      out  6   current apple grid y
//  apple_pix    out  1   scan pixel lies inside the apple cell
//  eat_count    out  8   apples eaten since reset/RESTART; saturates at 255
// BEHAVIOUR
//  Reset (rst=0, async): state=ARMED, add_cube=0, apple=(START_X,START_Y), eat_count=0, lfsr=LFSR_SEED.
//  game_status==RESTART: same values loaded synchronously on every clk edge while it is asserted.
//    RESTART overrides any state, including mid-EAT; add_cube is 0 after the next edge.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11; it advances every cycle in all states except reset/RESTART.
//  FSM:
//    ARMED: if game_status==PLAY and head==(apple_x,apple_y), then go to EAT next edge.
//      On that same edge: add_cube<=1, hold counter<=ADD_HOLD-1, eat_count++ (saturating).
//      No detection when game_status!=PLAY.
//    EAT: add_cube stays 1 while the hold counter is non-zero; the counter decrements each cycle.
//      When the counter is 0: add_cube<=0 and go to RELOCATE.
//      Total high time is exactly ADD_HOLD cycles. EAT completes regardless of game_status (except RESTART).
//    RELOCATE: every cycle, candidate cx=lfsr[5:0], cy=lfsr[13:8].
//      The candidate is accepted iff 1<=cx<=38, 1<=cy<=28 and (cx,cy)!=(head_x,head_y).
//      Accept: apple<=(cx,cy), go to ARMED. Reject: stay in RELOCATE and try the next LFSR value.
//      There is no cap on tries.
//  add_cube is low for >=1 cycle between eats (RELOCATE takes >=1 cycle).
//    This rearms the receiver's rise-detect handshake.
//  apple_x/apple_y keep the old value through EAT and RELOCATE and change only on accept.
//  apple_pix is combinational and has the same-cycle timing as the snake pixel classification.
//    It is 1 iff x_pos<640, y_pos<480, x_pos[9:4]==apple_x, y_pos[9:4]==apple_y and state==ARMED.
//    Otherwise it is 0, so the apple is hidden while eating/relocating.
//  Wall cells (grid x 0/39, y 0/29) are never legal apple cells.
//  Apple overlapping a body cell is permitted; only the head is excluded.
// TESTING
//  1 rst low mid-run -> add_cube=0, apple=(24,10), eat_count=0 immediately (async).
//  2 PLAY, head driven to (24,10) -> add_cube=1 on next edge for exactly 4 cycles.
//    Also eat_count=1, then a new apple in x 1..38, y 1..28, !=(24,10).
//  3 PLAY, scan x_pos=384..399, y_pos=160..175 -> apple_pix=1; x_pos=400 -> 0; during EAT -> 0.
//  4 game_status=2'b01, head on apple -> no add_cube, eat_count unchanged.
//    Then switch to PLAY -> eat fires.
//  5 RESTART asserted on the 2nd add_cube cycle -> add_cube=0 next edge, apple=(24,10), state ARMED.
//  6 Seed giving out-of-range first candidates (e.g. cx=0 or cx=45) -> rejects, no apple change.
//    Accept lands within legal range; 255 eats -> eat_count holds at 255.

Source files
------------

// File: rtl/apple_spawner.sv
// Apple food source for the snake game: detects the head landing on the apple, raises the grow
// request for a fixed hold time, relocates the apple via an LFSR and answers VGA pixel queries.
`timescale 1ns/1ps

module apple_spawner #(
   parameter int unsigned ADD_HOLD  = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter logic [5:0]  START_X   = 6'd24,
   parameter logic [5:0]  START_Y   = 6'd10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] game_status,
   input  logic [5:0] head_x,
   input  logic [5:0] head_y,
   input  logic [9:0] x_pos,
   input  logic [9:0] y_pos,
   output logic       add_cube,
   output logic [5:0] apple_x,
   output logic [5:0] apple_y,
   output logic       apple_pix,
   output logic [7:0] eat_count
);

   typedef enum logic [1:0] {
      ARMED    = 2'd0,
      EAT      = 2'd1,
      RELOCATE = 2'd2
   } state_t;

   localparam logic [1:0] GS_RESTART = 2'b00;
   localparam logic [1:0] GS_PLAY    = 2'b10;
   localparam logic [3:0] HOLD_INIT  = 4'(ADD_HOLD - 1);

   state_t      state, state_n;
   logic        add_n;
   logic [3:0]  hold_cnt, hold_n;
   logic [5:0]  apple_x_n, apple_y_n;
   logic [7:0]  eat_count_n;
   logic [15:0] lfsr, lfsr_n;

   logic        restart;
   logic        head_on_apple;
   logic [5:0]  cand_x, cand_y;
   logic        cand_ok;

   assign restart       = (game_status == GS_RESTART);
   assign head_on_apple = (head_x == apple_x) && (head_y == apple_y);

   // Taps 16,14,13,11 in 1-based numbering map to bits 15,13,12,10.
   assign lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   assign cand_x  = lfsr[5:0];
   assign cand_y  = lfsr[13:8];
   assign cand_ok = (cand_x >= 6'd1) && (cand_x <= 6'd38) &&
                    (cand_y >= 6'd1) && (cand_y <= 6'd28) &&
                    !((cand_x == head_x) && (cand_y == head_y));

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_n     = state;
      add_n       = add_cube;
      hold_n      = hold_cnt;
      apple_x_n   = apple_x;
      apple_y_n   = apple_y;
      eat_count_n = eat_count;
      unique case (state)
         ARMED: begin
            if ((game_status == GS_PLAY) && head_on_apple) begin
               state_n = EAT;
               add_n   = 1'b1;
               hold_n  = HOLD_INIT;
               if (eat_count != 8'hFF)
                  eat_count_n = eat_count + 8'd1;
            end
         end
         EAT: begin
            if (hold_cnt != 4'd0) begin
               hold_n = hold_cnt - 4'd1;
            end else begin
               add_n   = 1'b0;
               state_n = RELOCATE;
            end
         end
         RELOCATE: begin
            if (cand_ok) begin
               apple_x_n = cand_x;
               apple_y_n = cand_y;
               state_n   = ARMED;
            end
         end
         default: begin
            state_n = ARMED;
            add_n   = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ARMED;
         add_cube  <= 1'b0;
         hold_cnt  <= 4'd0;
         apple_x   <= START_X;
         apple_y   <= START_Y;
         eat_count <= 8'd0;
         lfsr      <= LFSR_SEED;
      end else if (restart) begin
         state     <= ARMED;
         add_cube  <= 1'b0;
         hold_cnt  <= 4'd0;
         apple_x   <= START_X;
         apple_y   <= START_Y;
         eat_count <= 8'd0;
         lfsr      <= LFSR_SEED;
      end else begin
         state     <= state_n;
         add_cube  <= add_n;
         hold_cnt  <= hold_n;
         apple_x   <= apple_x_n;
         apple_y   <= apple_y_n;
         eat_count <= eat_count_n;
         lfsr      <= lfsr_n;
      end
   end

   // Hidden outside ARMED so the apple vanishes while eating and relocating.
   assign apple_pix = (state == ARMED) &&
                      (x_pos < 10'd640) && (y_pos < 10'd480) &&
                      (x_pos[9:4] == apple_x) && (y_pos[9:4] == apple_y);

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner: reset, eat handshake, pixel window, status gating, RESTART
// and saturation, with a reference LFSR predicting each relocation.
`timescale 1ns/1ps

module tb_apple_spawner;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] game_status;
   logic [5:0] head_x, head_y;
   logic [9:0] x_pos, y_pos;
   logic       add_cube;
   logic [5:0] apple_x, apple_y;
   logic       apple_pix;
   logic [7:0] eat_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_lfsr;

   apple_spawner dut (
      .clk         (clk),
      .rst         (rst),
      .game_status (game_status),
      .head_x      (head_x),
      .head_y      (head_y),
      .x_pos       (x_pos),
      .y_pos       (y_pos),
      .add_cube    (add_cube),
      .apple_x     (apple_x),
      .apple_y     (apple_y),
      .apple_pix   (apple_pix),
      .eat_count   (eat_count)
   );

   always #5 clk = ~clk;

   // Reference Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
   always @(posedge clk or negedge rst) begin
      if (!rst)                      m_lfsr <= SEED;
      else if (game_status == 2'b00) m_lfsr <= SEED;
      else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit legal(input logic [5:0] cx, input logic [5:0] cy,
                                input logic [5:0] hx, input logic [5:0] hy);
      return (cx >= 1) && (cx <= 38) && (cy >= 1) && (cy <= 28) && !((cx == hx) && (cy == hy));
   endfunction

   // Called at the negedge of the first RELOCATE cycle; head stays on the old apple.
   task automatic relocate(input logic [5:0] ox, input logic [5:0] oy);
      bit done;
      done = 1'b0;
      for (int t = 0; t < 2000 && !done; t++) begin
         logic [5:0] cx, cy;
         cx = m_lfsr[5:0];
         cy = m_lfsr[13:8];
         @(negedge clk);
         if (legal(cx, cy, head_x, head_y)) begin
            check("apple_accept", {apple_x, apple_y}, {cx, cy});
            done = 1'b1;
         end else begin
            check("apple_reject_hold", {apple_x, apple_y}, {ox, oy});
         end
      end
      if (!done) check("relocate_timeout", 0, 1);
      check("apple_legal", legal(apple_x, apple_y, ox, oy), 1);
   endtask

   // Drive the head onto the apple in PLAY and follow the full eat / relocate sequence.
   task automatic eat_once(input logic [7:0] exp_count);
      logic [5:0] ox, oy;
      bit rose;
      int hi;
      ox = apple_x;
      oy = apple_y;
      x_pos = {ox, 4'd0};
      y_pos = {oy, 4'd0};
      #1 check("pix_armed", apple_pix, 1);
      head_x = ox;
      head_y = oy;
      rose = 1'b0;
      for (int i = 0; i < 20 && !rose; i++) begin
         @(negedge clk);
         rose = add_cube;
      end
      check("add_rise", rose, 1);
      if (!rose) return;
      check("apple_hold_eat", {apple_x, apple_y}, {ox, oy});
      check("pix_hidden_eat", apple_pix, 0);
      check("eat_count", eat_count, exp_count);
      hi = 0;
      for (int i = 0; i < 20 && add_cube; i++) begin
         hi++;
         @(negedge clk);
      end
      check("add_hold_len", hi, 4);
      relocate(ox, oy);
   endtask

   initial begin
      rst         = 1'b0;
      game_status = 2'b10;
      head_x      = 6'd0;
      head_y      = 6'd0;
      x_pos       = 10'd0;
      y_pos       = 10'd0;
      repeat (2) @(negedge clk);
      check("rst_add", add_cube, 0);
      check("rst_apple", {apple_x, apple_y}, {6'd24, 6'd10});
      check("rst_count", eat_count, 0);
      rst = 1'b1;
      @(negedge clk);

      // Pixel window of cell (24,10): x 384..399, y 160..175.
      x_pos = 10'd384; y_pos = 10'd160; #1 check("pix_384_160", apple_pix, 1);
      x_pos = 10'd399; y_pos = 10'd175; #1 check("pix_399_175", apple_pix, 1);
      x_pos = 10'd400; y_pos = 10'd160; #1 check("pix_400", apple_pix, 0);
      x_pos = 10'd383; y_pos = 10'd160; #1 check("pix_383", apple_pix, 0);
      x_pos = 10'd384; y_pos = 10'd176; #1 check("pix_y176", apple_pix, 0);

      // First eat at the start cell.
      eat_once(8'd1);

      // Not-playing status must block detection.
      begin
         bit seen;
         seen = 1'b0;
         game_status = 2'b01;
         head_x = apple_x;
         head_y = apple_y;
         repeat (6) begin
            @(negedge clk);
            seen = seen | add_cube;
         end
         check("gated_no_add", seen, 0);
         check("gated_count", eat_count, 1);
         game_status = 2'b10;
         eat_once(8'd2);
      end

      // RESTART on the second add_cube cycle.
      begin
         bit rose;
         rose = 1'b0;
         head_x = apple_x;
         head_y = apple_y;
         for (int i = 0; i < 20 && !rose; i++) begin
            @(negedge clk);
            rose = add_cube;
         end
         check("r_rise", rose, 1);
         @(negedge clk);
         check("r_add_2nd", add_cube, 1);
         game_status = 2'b00;
         @(negedge clk);
         check("r_add_low", add_cube, 0);
         check("r_apple", {apple_x, apple_y}, {6'd24, 6'd10});
         check("r_count", eat_count, 0);
         x_pos = 10'd390; y_pos = 10'd170;
         #1 check("r_armed_pix", apple_pix, 1);
         @(negedge clk);
         game_status = 2'b10;
      end

      // Many eats: relocation rejects/accepts tracked, counter saturates.
      for (int k = 0; k < 256; k++) begin
         eat_once((k < 255) ? 8'(k + 1) : 8'd255);
         if (k == 254) check("sat_255", eat_count, 255);
      end
      check("sat_hold", eat_count, 255);

      // Asynchronous reset in the middle of an eat.
      begin
         bit rose;
         rose = 1'b0;
         head_x = apple_x;
         head_y = apple_y;
         for (int i = 0; i < 20 && !rose; i++) begin
            @(negedge clk);
            rose = add_cube;
         end
         check("a_rise", rose, 1);
         #2 rst = 1'b0;
         #1;
         check("a_add", add_cube, 0);
         check("a_apple", {apple_x, apple_y}, {6'd24, 6'd10});
         check("a_count", eat_count, 0);
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
